// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU adder arbiter: FSM state encoding,
// IEEE single width and the grant index width.
package fpu_arb_pkg;

    localparam int FP_W    = 32;
    localparam int GRANT_W = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SEND_A  = 3'd2,
        SEND_B  = 3'd3,
        WAIT_Z  = 3'd4,
        DELIVER = 3'd5
    } state_t;

endpackage

// File: rtl/fpu_add_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester above 'last' wins,
// wrapping to index 0 when nothing above it is requesting.
module rr_pick
    import fpu_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       req,
    input  logic [GRANT_W-1:0] last,
    output logic [N-1:0]       win_oh,
    output logic [GRANT_W-1:0] win_idx
);

    logic found;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        // Pass 1 covers last+1..N-1, pass 2 wraps around to 0..last.
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j > int'(last))) begin
                found     = 1'b1;
                win_oh[j] = 1'b1;
                win_idx   = GRANT_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j <= int'(last))) begin
                found     = 1'b1;
                win_oh[j] = 1'b1;
                win_idx   = GRANT_W'(j);
            end
        end
    end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one FPU adder between N requesters; one
// operation in flight, result returned only to the granted requester.
module fpu_add_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = FP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_stb,
    input  logic [N*W-1:0]     req_a,
    input  logic [N*W-1:0]     req_b,
    output logic [N-1:0]       req_ack,
    output logic [W-1:0]       res_z,
    output logic [N-1:0]       res_stb,
    input  logic [N-1:0]       res_ack,
    output logic [W-1:0]       add_a,
    output logic               add_a_stb,
    input  logic               add_a_ack,
    output logic [W-1:0]       add_b,
    output logic               add_b_stb,
    input  logic               add_b_ack,
    input  logic [W-1:0]       add_z,
    input  logic               add_z_stb,
    output logic               add_z_ack,
    output logic [GRANT_W-1:0] grant,
    output logic               busy,
    output logic [15:0]        ops_done,
    output state_t             dbg_state
);

    // Handshake rule on every channel: a transfer happens on the clock edge
    // where stb and ack are both high; the owner of each line drops it on the
    // cycle after that transfer and otherwise holds it steady.

    state_t             state, state_n;
    logic [N-1:0]       g_oh, g_oh_n;
    logic [GRANT_W-1:0] last, last_n, grant_n;
    logic [W-1:0]       b_reg, b_reg_n;
    logic [N-1:0]       req_ack_n, res_stb_n;
    logic [W-1:0]       res_z_n, add_a_n, add_b_n;
    logic               add_a_stb_n, add_b_stb_n, add_z_ack_n, busy_n;
    logic [15:0]        ops_done_n;

    logic [N-1:0]       win_oh;
    logic [GRANT_W-1:0] win_idx;
    logic [W-1:0]       sel_a, sel_b;
    logic               g_req, g_res_ack;

    rr_pick #(.N(N)) u_pick (
        .req     (req_stb),
        .last    (last),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int j = 0; j < N; j++) begin
            if (g_oh[j]) begin
                sel_a = req_a[j*W +: W];
                sel_b = req_b[j*W +: W];
            end
        end
    end

    // Only the granted requester's lines are observed while an op is in flight.
    assign g_req     = |(req_stb & g_oh);
    assign g_res_ack = |(res_ack & g_oh);
    assign dbg_state = state;

    always_comb begin
        state_n     = state;
        g_oh_n      = g_oh;
        last_n      = last;
        grant_n     = grant;
        b_reg_n     = b_reg;
        req_ack_n   = req_ack;
        res_stb_n   = res_stb;
        res_z_n     = res_z;
        add_a_n     = add_a;
        add_b_n     = add_b;
        add_a_stb_n = add_a_stb;
        add_b_stb_n = add_b_stb;
        add_z_ack_n = add_z_ack;
        busy_n      = busy;
        ops_done_n  = ops_done;
        case (state)
            IDLE: begin
                if (|req_stb) begin
                    grant_n   = win_idx;
                    g_oh_n    = win_oh;
                    req_ack_n = win_oh;
                    busy_n    = 1'b1;
                    state_n   = CAPTURE;
                end
            end
            CAPTURE: begin
                req_ack_n = '0;
                // add_a doubles as the operand-a register; b waits in b_reg.
                if (g_req) begin
                    add_a_n     = sel_a;
                    b_reg_n     = sel_b;
                    add_a_stb_n = 1'b1;
                    state_n     = SEND_A;
                end else begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            SEND_A: begin
                if (add_a_ack) begin
                    add_a_stb_n = 1'b0;
                    add_b_n     = b_reg;
                    add_b_stb_n = 1'b1;
                    state_n     = SEND_B;
                end
            end
            SEND_B: begin
                if (add_b_ack) begin
                    add_b_stb_n = 1'b0;
                    add_z_ack_n = 1'b1;
                    state_n     = WAIT_Z;
                end
            end
            WAIT_Z: begin
                if (add_z_stb) begin
                    add_z_ack_n = 1'b0;
                    res_z_n     = add_z;
                    res_stb_n   = g_oh;
                    state_n     = DELIVER;
                end
            end
            DELIVER: begin
                if (g_res_ack) begin
                    res_stb_n  = '0;
                    last_n     = grant;
                    ops_done_n = ops_done + 16'd1;
                    busy_n     = 1'b0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            g_oh      <= '0;
            last      <= GRANT_W'(N - 1);
            grant     <= '0;
            b_reg     <= '0;
            req_ack   <= '0;
            res_stb   <= '0;
            res_z     <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_a_stb <= 1'b0;
            add_b_stb <= 1'b0;
            add_z_ack <= 1'b0;
            busy      <= 1'b0;
            ops_done  <= '0;
        end else begin
            state     <= state_n;
            g_oh      <= g_oh_n;
            last      <= last_n;
            grant     <= grant_n;
            b_reg     <= b_reg_n;
            req_ack   <= req_ack_n;
            res_stb   <= res_stb_n;
            res_z     <= res_z_n;
            add_a     <= add_a_n;
            add_b     <= add_b_n;
            add_a_stb <= add_a_stb_n;
            add_b_stb <= add_b_stb_n;
            add_z_ack <= add_z_ack_n;
            busy      <= busy_n;
            ops_done  <= ops_done_n;
        end
    end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter: negedge-driven requester and adder
// models, an expected-result queue, and immediate assertions per check.
module tb_fpu_add_arbiter;
    import fpu_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [N-1:0]       req_stb = '0;
    logic [N*W-1:0]     req_a = '0;
    logic [N*W-1:0]     req_b = '0;
    logic [N-1:0]       req_ack;
    logic [W-1:0]       res_z;
    logic [N-1:0]       res_stb;
    logic [N-1:0]       res_ack = '0;
    logic [W-1:0]       add_a;
    logic               add_a_stb;
    logic               add_a_ack = 1'b0;
    logic [W-1:0]       add_b;
    logic               add_b_stb;
    logic               add_b_ack = 1'b0;
    logic [W-1:0]       add_z = '0;
    logic               add_z_stb = 1'b0;
    logic               add_z_ack;
    logic [GRANT_W-1:0] grant;
    logic               busy;
    logic [15:0]        ops_done;
    state_t             dbg_state;

    fpu_add_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_stb   (req_stb),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ack   (req_ack),
        .res_z     (res_z),
        .res_stb   (res_stb),
        .res_ack   (res_ack),
        .add_a     (add_a),
        .add_a_stb (add_a_stb),
        .add_a_ack (add_a_ack),
        .add_b     (add_b),
        .add_b_stb (add_b_stb),
        .add_b_ack (add_b_ack),
        .add_z     (add_z),
        .add_z_stb (add_z_stb),
        .add_z_ack (add_z_ack),
        .grant     (grant),
        .busy      (busy),
        .ops_done  (ops_done),
        .dbg_state (dbg_state)
    );

    // ---------------- configuration (written by the directed sequence) ----
    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];
    int           want [N];
    int           rdly [N];
    logic         withdraw [N];
    int           a_dly = 0;
    int           b_dly = 0;
    int           z_dly = 0;

    // ---------------- model state (written by the negedge models) ----------
    int           issued [N] = '{default: 0};
    logic         ack_seen [N] = '{default: 1'b0};
    logic         wait_res [N] = '{default: 1'b0};
    int           rcnt [N] = '{default: 0};
    logic [W-1:0] rz [N] = '{default: '0};
    logic         w_done = 1'b0;
    logic [31:0]  got_id [$];
    logic [W-1:0] got_z [$];
    int           mph = 0;
    int           mcnt = 0;
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;
    int           a_xfer = 0;
    int           drop_err = 0;
    int           busy_cnt = 0;
    logic [N-1:0] res_or = '0;
    logic         p_rst = 1'b1;
    logic         p_a_stb = 1'b0, p_a_ack = 1'b0, p_b_stb = 1'b0, p_b_ack = 1'b0;
    logic         p_z_stb = 1'b0, p_z_ack = 1'b0;
    logic [N-1:0] p_res_stb = '0, p_res_ack = '0;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q [$];
    logic [31:0]  exp_g [$];
    int           sb_idx = 0;
    int           checks = 0;
    int           failures = 0;

    function automatic logic [W-1:0] mock_add(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    // Protocol monitor, adder model and requester models, all at negedge.
    always @(negedge clk) begin
        if (!rst && !p_rst) begin
            if (p_a_stb && !p_a_ack && !add_a_stb) drop_err++;
            if (p_b_stb && !p_b_ack && !add_b_stb) drop_err++;
            if (p_z_ack && !p_z_stb && !add_z_ack) drop_err++;
            if ((p_res_stb & ~p_res_ack & ~res_stb) != '0) drop_err++;
        end
        res_or = res_or | res_stb;
        if (busy) busy_cnt++;

        if (rst) begin
            add_a_ack = 1'b0;
            add_b_ack = 1'b0;
            add_z_stb = 1'b0;
            mph       = 0;
            mcnt      = 0;
        end else begin
            if (mph == 0 && add_a_ack) begin
                add_a_ack = 1'b0; mph = 1; mcnt = 0; a_xfer++;
            end else if (mph == 0 && add_a_stb) begin
                if (mcnt >= a_dly) begin add_a_ack = 1'b1; ma = add_a; end
                else mcnt++;
            end
            if (mph == 1 && add_b_ack) begin
                add_b_ack = 1'b0; mph = 2; mcnt = 0;
            end else if (mph == 1 && add_b_stb) begin
                if (mcnt >= b_dly) begin add_b_ack = 1'b1; mb = add_b; end
                else mcnt++;
            end
            if (mph == 3) begin
                add_z_stb = 1'b0; mph = 0;
            end else if (mph == 2) begin
                if (mcnt >= z_dly) begin add_z = mock_add(ma, mb); add_z_stb = 1'b1; mph = 3; end
                else mcnt++;
            end
        end

        for (int i = 0; i < N; i++) begin
            if (rst) begin
                req_stb[i] = 1'b0; ack_seen[i] = 1'b0; wait_res[i] = 1'b0;
                res_ack[i] = 1'b0; rcnt[i] = 0;
            end else begin
                if (req_stb[i] && ack_seen[i]) begin
                    req_stb[i] = 1'b0; ack_seen[i] = 1'b0; wait_res[i] = 1'b1;
                end else if (req_stb[i] && req_ack[i]) begin
                    if (withdraw[i] && !w_done) begin req_stb[i] = 1'b0; w_done = 1'b1; end
                    else ack_seen[i] = 1'b1;
                end
                if (res_ack[i]) begin
                    res_ack[i] = 1'b0; wait_res[i] = 1'b0;
                    got_id.push_back(32'(i)); got_z.push_back(rz[i]);
                end else if (res_stb[i]) begin
                    if (rcnt[i] >= rdly[i]) begin res_ack[i] = 1'b1; rz[i] = res_z; rcnt[i] = 0; end
                    else rcnt[i]++;
                end
                if (!req_stb[i] && !wait_res[i] && issued[i] < want[i]) begin
                    req_stb[i] = 1'b1;
                    req_a[i*W +: W] = op_a[i];
                    req_b[i*W +: W] = op_b[i];
                    issued[i]++;
                end
            end
        end

        p_rst = rst;
        p_a_stb = add_a_stb; p_a_ack = add_a_ack;
        p_b_stb = add_b_stb; p_b_ack = add_b_ack;
        p_z_stb = add_z_stb; p_z_ack = add_z_ack;
        p_res_stb = res_stb; p_res_ack = res_ack;
    end

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wait_served(input int n, input int budget, input string tag);
        int k = 0;
        while (got_z.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(tag, 32'(got_z.size()), 32'(n));
    endtask

    task automatic wait_state(input state_t s, input int budget, input string tag);
        int k = 0;
        while (dbg_state !== s && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, 32'(dbg_state), 32'(s));
    endtask

    task automatic drain_sb(input string tag);
        logic [31:0] gid;
        logic [W-1:0] gz;
        while (exp_q.size() != 0) begin
            gid = (sb_idx < got_id.size()) ? got_id[sb_idx] : 32'hFFFF_FFFF;
            gz  = (sb_idx < got_z.size())  ? got_z[sb_idx]  : 32'hFFFF_FFFF;
            chk({tag, "_grant"}, gid, exp_g.pop_front());
            chk({tag, "_z"}, gz, exp_q.pop_front());
            sb_idx++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int b0, d0, x0;
    initial begin
        for (int i = 0; i < N; i++) begin
            op_a[i] = 32'h1000 + 32'(i);
            op_b[i] = 32'h10 * 32'(i + 1);
            want[i] = 0;
            rdly[i] = 0;
            withdraw[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ack", 32'(req_ack), 0);
        chk("rst_res_stb", 32'(res_stb), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ops_done", 32'(ops_done), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_add_stbs", {29'd0, add_a_stb, add_b_stb, add_z_ack}, 0);
        chk("rst_res_z", res_z, 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk) rst = 1'b0;

        // Single request, requester 0: 1.0 + 2.0 = 3.0
        op_a[0] = 32'h3F80_0000;
        op_b[0] = 32'h4000_0000;
        exp_q.push_back(32'h4040_0000); exp_g.push_back(0);
        b0 = busy_cnt;
        want[0] = 1;
        wait_served(1, 100, "t1_done");
        drain_sb("t1");
        chk("t1_res_stb_only0", 32'(res_or), 32'b0001);
        chk("t1_ops_done", 32'(ops_done), 1);
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_busy_cycles", 32'(busy_cnt - b0), 5);
        chk("t1_res_z_hold", res_z, 32'h4040_0000);
        op_a[0] = 32'h1000;
        op_b[0] = 32'h10;

        // Contention: all four at once, 0 and 1 re-request right away
        do_reset();
        exp_q = '{32'h1010, 32'h1021, 32'h1032, 32'h1043, 32'h1010, 32'h1021};
        exp_g = '{0, 1, 2, 3, 0, 1};
        want[0] = want[0] + 2;
        want[1] = 2;
        want[2] = 1;
        want[3] = 1;
        wait_served(7, 300, "t2_done");
        drain_sb("t2");
        chk("t2_ops_done", 32'(ops_done), 6);

        // Backpressure on every channel
        a_dly = 3; b_dly = 5; z_dly = 20; rdly[2] = 7;
        op_a[2] = 32'h40A0_0000;
        op_b[2] = 32'h0000_0001;
        exp_q.push_back(32'h40A0_0001); exp_g.push_back(2);
        d0 = drop_err;
        want[2]++;
        wait_state(WAIT_Z, 100, "t3_reach_wait_z");
        repeat (5) @(posedge clk);
        #1;
        chk("t3_in_wait_z", 32'(dbg_state), 32'(WAIT_Z));
        chk("t3_z_ack_held", 32'(add_z_ack), 1);
        chk("t3_busy_mid", 32'(busy), 1);
        chk("t3_grant", 32'(grant), 2);
        wait_served(8, 200, "t3_done");
        drain_sb("t3");
        chk("t3_lines_held", 32'(drop_err - d0), 0);
        chk("t3_add_b_seen", mb, 32'h1);
        chk("t3_ops_done", 32'(ops_done), 7);
        a_dly = 0; b_dly = 0; z_dly = 0; rdly[2] = 0;

        // Withdrawal: requester 2 drops out in CAPTURE while 3 waits
        do_reset();
        x0 = a_xfer;
        withdraw[2] = 1'b1;
        want[2]++;
        want[3]++;
        for (int k = 0; k < 50 && !w_done; k++) @(posedge clk);
        chk("t4_withdraw_seen", 32'(w_done), 1);
        #1;
        chk("t4_back_to_idle", 32'(dbg_state), 32'(IDLE));
        chk("t4_ack_cleared", 32'(req_ack), 0);
        @(posedge clk);
        #1;
        chk("t4_next_grant", 32'(grant), 3);
        chk("t4_next_ack", 32'(req_ack), 32'b1000);
        exp_q.push_back(32'h1043); exp_g.push_back(3);
        wait_served(9, 100, "t4_done");
        drain_sb("t4");
        chk("t4_one_a_xfer", 32'(a_xfer - x0), 1);
        chk("t4_a_from_3", ma, 32'h1003);
        chk("t4_ops_done", 32'(ops_done), 1);

        // Reset while requester 1 sits in WAIT_Z
        z_dly = 30;
        want[1]++;
        wait_state(WAIT_Z, 100, "t5_reach_wait_z");
        chk("t5_grant", 32'(grant), 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_state", 32'(dbg_state), 32'(IDLE));
        chk("t5_req_ack", 32'(req_ack), 0);
        chk("t5_res_stb", 32'(res_stb), 0);
        chk("t5_add_stbs", {29'd0, add_a_stb, add_b_stb, add_z_ack}, 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ops_done", 32'(ops_done), 0);
        chk("t5_grant_rst", 32'(grant), 0);
        chk("t5_add_a", add_a, 0);
        chk("t5_add_b", add_b, 0);
        chk("t5_res_z", res_z, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        z_dly = 0;
        exp_q.push_back(32'h1021); exp_g.push_back(1);
        want[1]++;
        wait_served(10, 100, "t5_done");
        drain_sb("t5");
        chk("t5_ops_after", 32'(ops_done), 1);

        // ops_done wrap from 0xFFFF
        @(negedge clk) force dut.ops_done = 16'hFFFF;
        @(negedge clk) release dut.ops_done;
        exp_q.push_back(32'h1010); exp_g.push_back(0);
        want[0]++;
        wait_served(11, 100, "t6_done");
        drain_sb("t6");
        chk("t6_wrap", 32'(ops_done), 0);
        chk("t6_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
